// File: rtl/i2s_receiver.sv
// I2S slave receiver for the ADC capture path.
// The codec bclk/lrclk/sdata lines are synchronised into the clk domain.
// Each left/right word is deserialised MSB first. Complete stereo frames
// are buffered in a small FIFO that the bus side drains.
//
// Consumer handshake: frame_valid means the FIFO head (frame_l/frame_r) holds
// a stored frame. When frame_valid and frame_ready are both 1 on a rising clk
// edge, the head frame is consumed. The next entry appears on the following
// cycle. frame_valid never depends on frame_ready.
module i2s_receiver #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH   = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bclk,
    input  logic                          lrclk,
    input  logic                          sdata,
    input  logic                          enable,
    output logic [SAMPLE_WIDTH-1:0]       frame_l,
    output logic [SAMPLE_WIDTH-1:0]       frame_r,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clear_flags
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam int FW = 2 * SAMPLE_WIDTH;
    localparam logic [CW-1:0] SW_C    = CW'(SAMPLE_WIDTH);
    localparam logic [CW-1:0] SW_M1_C = CW'(SAMPLE_WIDTH - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    // Synchroniser chains; all three lines are read from the same stage
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrclk_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_q;
    logic                   bclk_prev_q;

    logic bclk_s;
    logic lr_s;
    logic sdata_s;
    logic tick;

    // Deserialiser state
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                    left_ok_q, left_ok_d;
    logic                    aligned_q, aligned_d;
    logic                    prev_lr_q, prev_lr_d;
    logic [SAMPLE_WIDTH-1:0] shifted;
    logic                    push;
    logic                    err_set;

    // FIFO state
    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full;
    logic          pop;
    logic          push_ok;
    logic [FW-1:0] head;

    logic overflow_q;
    logic frame_err_q;

    assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
    assign lr_s    = lrclk_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
    assign tick    = bclk_s & ~bclk_prev_q;
    assign shifted = {shift_q[SAMPLE_WIDTH-2:0], sdata_s};

    // Shift the asynchronous inputs through the synchroniser chains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync_q  <= '0;
            lrclk_sync_q <= '0;
            sdata_sync_q <= '0;
            bclk_prev_q  <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
            lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk};
            sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], sdata};
            bclk_prev_q  <= bclk_s;
        end
    end

    // Per-tick deserialiser: word boundaries, bit capture and frame push
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        aligned_d   = aligned_q;
        prev_lr_d   = prev_lr_q;
        push        = 1'b0;
        err_set     = 1'b0;
        if (tick) begin
            prev_lr_d = lr_s;
            if (lr_s != prev_lr_q) begin
                // The boundary bit is the I2S one-bit delay slot; drop it
                bit_cnt_d = '0;
                shift_d   = '0;
                if (bit_cnt_q < SW_C && aligned_q) begin
                    err_set   = 1'b1;
                    left_ok_d = 1'b0;
                end
                if (!lr_s) begin
                    aligned_d = 1'b1;
                end
            end else if (bit_cnt_q < SW_C) begin
                shift_d   = shifted;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == SW_M1_C) begin
                    if (!lr_s) begin
                        left_hold_d = shifted;
                        left_ok_d   = aligned_q;
                    end else if (left_ok_q) begin
                        push      = 1'b1;
                        left_ok_d = 1'b0;
                    end
                end
            end
        end
        // Disabled: forget alignment so capture restarts on a left start
        if (!enable) begin
            bit_cnt_d = '0;
            left_ok_d = 1'b0;
            aligned_d = 1'b0;
            push      = 1'b0;
            err_set   = 1'b0;
        end
    end

    // Deserialiser state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            aligned_q   <= 1'b0;
            prev_lr_q   <= 1'b1;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            aligned_q   <= aligned_d;
            prev_lr_q   <= prev_lr_d;
        end
    end

    assign full        = (count_q == DEPTH_C);
    assign frame_valid = (count_q != '0);
    assign pop         = frame_valid & frame_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok     = push & (~full | pop);
    assign head        = mem_q[rd_ptr_q];
    assign frame_l     = head[FW-1:SAMPLE_WIDTH];
    assign frame_r     = head[SAMPLE_WIDTH-1:0];
    assign fill_level  = count_q;
    assign overflow    = overflow_q;
    assign frame_err   = frame_err_q;

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {left_hold_q, shifted};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Sticky status flags; clear wins over a simultaneous set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (clear_flags) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (err_set) begin
                frame_err_q <= 1'b1;
            end
        end
    end

endmodule
